// File: rtl/eth_wb_slave_arbiter.sv
// Round-robin arbiter sharing the ethmac Wishbone register port between NREQ masters.
// Define ETH_ARB_TIMEOUT_EN to add a watchdog that ends hung slave cycles with err.
module eth_wb_slave_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 10,
    parameter int TIMEOUT = 64
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NREQ-1:0]      req_cyc_i,
    input  logic [NREQ-1:0]      req_stb_i,
    input  logic [NREQ-1:0]      req_we_i,
    input  logic [NREQ*AW-1:0]   req_adr_i,
    input  logic [NREQ*4-1:0]    req_sel_i,
    input  logic [NREQ*32-1:0]   req_dat_i,
    output logic [31:0]          req_dat_o,
    output logic [NREQ-1:0]      req_ack_o,
    output logic [NREQ-1:0]      req_err_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [3:0]           s_sel_o,
    output logic [31:0]          s_dat_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 timeout_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if ((NREQ < 2) || (NREQ > 4) || (TIMEOUT < 2)) begin : g_cfg_check
        $error("eth_wb_slave_arbiter: NREQ must be 2..4 and TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RELEASE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cur_q, ptr_q, ptr_inc, start, win;
    logic [NREQ-1:0] pend, pend_eff;
    logic            any_pend, grant, abort, term, term_ack, to_hit, to_fire;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Lowest offset from s wins; scanning downward lets the nearest hit overwrite.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] p, input logic [IW-1:0] s);
        logic [IW-1:0] pick;
        int            j;
        pick = s;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(s) + i;
            if (j >= NREQ) j -= NREQ;
            if (p[j]) pick = IW'(j);
        end
        return pick;
    endfunction

`ifdef ETH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q;

    assign to_hit = (state_q == BUS) && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q != BUS) cnt_q <= '0;
        else                            cnt_q <= cnt_q + CW'(1);
    end
`else
    assign to_hit = 1'b0;
`endif

    assign ptr_inc = (cur_q == IW'(NREQ - 1)) ? '0 : cur_q + IW'(1);

    always_comb begin
        pend     = req_cyc_i & req_stb_i;
        start    = ptr_q;
        pend_eff = pend;
        // Leaving a transfer: the previous owner goes last and is skipped entirely,
        // so a master still holding stb in its ack cycle is not granted twice.
        if (state_q == RELEASE) begin
            start    = ptr_inc;
            pend_eff = pend & ~onehot(cur_q);
        end
        any_pend = |pend_eff;
        win      = rr_pick(pend_eff, start);
        abort    = ~req_cyc_i[cur_q];
        term     = s_ack_i | s_err_i | to_hit;
        term_ack = s_ack_i & ~s_err_i;
        to_fire  = to_hit & ~s_ack_i & ~s_err_i;
        grant    = 1'b0;
        state_d  = state_q;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    grant   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (abort || term) state_d = RELEASE;
            end
            RELEASE: begin
                grant   = any_pend;
                state_d = any_pend ? BUS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            ptr_q     <= '0;
            gnt_o     <= '0;
            s_cyc_o   <= 1'b0;
            s_stb_o   <= 1'b0;
            s_we_o    <= 1'b0;
            s_adr_o   <= '0;
            s_sel_o   <= '0;
            s_dat_o   <= '0;
            req_ack_o <= '0;
            req_err_o <= '0;
            req_dat_o <= '0;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_ack_o <= '0;
            req_err_o <= '0;
            timeout_o <= 1'b0;
            if (state_q == RELEASE) ptr_q <= ptr_inc;
            if (grant) begin
                cur_q   <= win;
                gnt_o   <= onehot(win);
                s_cyc_o <= 1'b1;
                s_stb_o <= 1'b1;
                s_we_o  <= req_we_i[win];
                s_adr_o <= req_adr_i[int'(win)*AW +: AW];
                s_sel_o <= req_sel_i[int'(win)*4 +: 4];
                s_dat_o <= req_dat_i[int'(win)*32 +: 32];
            end else if (state_q == BUS && (abort || term)) begin
                gnt_o   <= '0;
                s_cyc_o <= 1'b0;
                s_stb_o <= 1'b0;
                // An aborting master has gone away, so it gets no termination.
                if (!abort) begin
                    if (term_ack) begin
                        req_ack_o <= onehot(cur_q);
                        if (!s_we_o) req_dat_o <= s_dat_i;
                    end else begin
                        req_err_o <= onehot(cur_q);
                    end
                    timeout_o <= to_fire;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_wb_slave_arbiter.sv
// Self-checking bench for eth_wb_slave_arbiter: per-cycle model comparison plus
// directed scenarios with literal expectations.
module tb_eth_wb_slave_arbiter;

    localparam int NREQ    = 2;
    localparam int AW      = 10;
    localparam int TIMEOUT = 64;

    logic                 wb_clk_i = 1'b0;
    logic                 wb_rst_i = 1'b1;
    logic [NREQ-1:0]      req_cyc_i = '0, req_stb_i = '0, req_we_i = '0;
    logic [NREQ*AW-1:0]   req_adr_i = '0;
    logic [NREQ*4-1:0]    req_sel_i = '0;
    logic [NREQ*32-1:0]   req_dat_i = '0;
    logic [31:0]          req_dat_o;
    logic [NREQ-1:0]      req_ack_o, req_err_o, gnt_o;
    logic                 s_cyc_o, s_stb_o, s_we_o, timeout_o;
    logic [AW-1:0]        s_adr_o;
    logic [3:0]           s_sel_o;
    logic [31:0]          s_dat_o;
    logic [31:0]          s_dat_i = '0;
    logic                 s_ack_i = 1'b0, s_err_i = 1'b0;

    eth_wb_slave_arbiter #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_cyc_i(req_cyc_i), .req_stb_i(req_stb_i), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_dat_i(req_dat_i),
        .req_dat_o(req_dat_o), .req_ack_o(req_ack_o), .req_err_o(req_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Slave: mode 0 ack, 1 err, 2 ack+err, 3 never; responds sl_lat cycles into the strobe.
    int          sl_mode = 0;
    int          sl_lat  = 1;
    int          sl_cnt  = 0;
    logic [31:0] sl_rdata = 32'h0;

    always @(negedge wb_clk_i) begin
        if (s_cyc_o && s_stb_o) begin
            sl_cnt++;
            if (sl_mode != 3 && sl_cnt == sl_lat) begin
                s_ack_i = (sl_mode != 1);
                s_err_i = (sl_mode != 0);
                s_dat_i = sl_rdata;
            end else begin
                s_ack_i = 1'b0;
                s_err_i = 1'b0;
                s_dat_i = 32'hdeadbeef;
            end
        end else begin
            sl_cnt  = 0;
            s_ack_i = 1'b0;
            s_err_i = 1'b0;
            s_dat_i = 32'hdeadbeef;
        end
    end

    // Reference model: phase 0 idle, 1 owner on the bus, 2 just finished.
    int              m_phase = 0, m_own = 0, m_ptr = 0, m_cnt = 0;
    logic [NREQ-1:0] e_gnt = '0, e_ack = '0, e_err = '0;
    logic            e_cyc = 1'b0, e_we = 1'b0, e_to = 1'b0;
    logic [AW-1:0]   e_adr = '0;
    logic [3:0]      e_sel = '0;
    logic [31:0]     e_wdat = '0, e_rdat = '0;

    always @(posedge wb_clk_i) begin : model
        int  excl, found, r;
        bit  tohit;
        e_ack = '0;
        e_err = '0;
        e_to  = 1'b0;
        if (wb_rst_i) begin
            m_phase = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
            e_gnt = '0; e_cyc = 1'b0; e_we = 1'b0; e_adr = '0; e_sel = '0;
            e_wdat = '0; e_rdat = '0;
        end else if (m_phase == 1) begin
            tohit = 1'b0;
`ifdef ETH_ARB_TIMEOUT_EN
            tohit = (m_cnt == TIMEOUT - 1);
`endif
            if (!req_cyc_i[m_own]) begin
                e_gnt = '0; e_cyc = 1'b0; m_phase = 2;
            end else if (s_ack_i || s_err_i || tohit) begin
                e_gnt = '0; e_cyc = 1'b0; m_phase = 2;
                if (s_ack_i && !s_err_i) begin
                    e_ack[m_own] = 1'b1;
                    if (!e_we) e_rdat = s_dat_i;
                end else begin
                    e_err[m_own] = 1'b1;
                    e_to = !s_ack_i && !s_err_i;
                end
            end else begin
                m_cnt++;
            end
        end else begin
            excl = -1;
            if (m_phase == 2) begin
                m_ptr = (m_own + 1) % NREQ;
                excl  = m_own;
            end
            found = -1;
            for (int k = 0; k < NREQ; k++) begin
                r = (m_ptr + k) % NREQ;
                if (found < 0 && r != excl && req_cyc_i[r] && req_stb_i[r]) found = r;
            end
            if (found >= 0) begin
                m_own = found;
                e_gnt = '0;
                e_gnt[found] = 1'b1;
                e_cyc  = 1'b1;
                e_we   = req_we_i[found];
                e_adr  = req_adr_i[found*AW +: AW];
                e_sel  = req_sel_i[found*4 +: 4];
                e_wdat = req_dat_i[found*32 +: 32];
                m_cnt  = 0;
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(posedge wb_clk_i) begin
        #2;
        chk("cyc_gnt", gnt_o, e_gnt);
        chk("cyc_s_cyc", s_cyc_o, e_cyc);
        chk("cyc_s_stb", s_stb_o, e_cyc);
        chk("cyc_s_we", s_we_o, e_we);
        chk("cyc_s_adr", s_adr_o, e_adr);
        chk("cyc_s_sel", s_sel_o, e_sel);
        chk("cyc_s_dat", s_dat_o, e_wdat);
        chk("cyc_ack", req_ack_o, e_ack);
        chk("cyc_err", req_err_o, e_err);
        chk("cyc_rdat", req_dat_o, e_rdat);
        chk("cyc_timeout", timeout_o, e_to);
    end

    task automatic set_req(input int r, input logic we, input logic [AW-1:0] adr, input logic [31:0] dat);
        req_cyc_i[r] = 1'b1;
        req_stb_i[r] = 1'b1;
        req_we_i[r]  = we;
        req_adr_i[r*AW +: AW] = adr;
        req_sel_i[r*4 +: 4]   = 4'hf;
        req_dat_i[r*32 +: 32] = dat;
    endtask

    task automatic clr_req(input int r);
        req_cyc_i[r] = 1'b0;
        req_stb_i[r] = 1'b0;
    endtask

    task automatic wait_stb(input string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge wb_clk_i);
            if (s_stb_o) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_wait_stb actual=no_strobe required=strobe_within_200", nm);
    endtask

    task automatic wait_term(input int r, input string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge wb_clk_i);
            if (req_ack_o[r] || req_err_o[r]) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_wait_term actual=no_ack_err required=termination_within_200", nm);
    endtask

    int exp_seq[4] = '{0, 1, 0, 1};

    initial begin
        int          gseq[$];
        int          gap[$];
        int          zeros, n;
        logic [1:0]  prev;

        repeat (3) @(negedge wb_clk_i);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_ack", req_ack_o, 0);
        chk("rst_rdat", req_dat_o, 0);
        chk("rst_timeout", timeout_o, 0);
        wb_rst_i = 1'b0;

        // Two masters streaming from reset
        sl_mode = 0; sl_lat = 1;
        set_req(0, 1'b1, 10'h001, 32'h1111_0000);
        set_req(1, 1'b1, 10'h002, 32'h2222_0000);
        prev = '0; zeros = 0;
        for (int i = 0; i < 40 && gseq.size() < 4; i++) begin
            @(negedge wb_clk_i);
            if (gnt_o != 0 && prev == 0) begin
                gseq.push_back(gnt_o[1] ? 1 : 0);
                if (gseq.size() > 1) gap.push_back(zeros);
                zeros = 0;
            end else if (gnt_o == 0) begin
                zeros++;
            end
            prev = gnt_o;
        end
        chk("t2_grant_count", gseq.size(), 4);
        foreach (gseq[i]) chk($sformatf("t2_grant%0d", i), gseq[i], exp_seq[i]);
        foreach (gap[i]) chk($sformatf("t2_gap%0d", i), gap[i], 1);
        clr_req(0); clr_req(1);
        repeat (4) @(negedge wb_clk_i);

        // Single write, slave acks two cycles into the strobe
        sl_mode = 0; sl_lat = 2;
        set_req(0, 1'b1, 10'h000, 32'h0000a40b);
        wait_stb("t1");
        chk("t1_s_dat_o", s_dat_o, 32'h0000a40b);
        chk("t1_s_we_o", s_we_o, 1);
        chk("t1_gnt", gnt_o, 2'b01);
        wait_term(0, "t1");
        chk("t1_ack", req_ack_o, 2'b01);
        chk("t1_err", req_err_o, 2'b00);
        clr_req(0);
        @(negedge wb_clk_i);
        chk("t1_ack_one_cycle", req_ack_o, 2'b00);
        chk("t1_gnt_release", gnt_o, 2'b00);
        @(negedge wb_clk_i);
        chk("t1_gnt_idle", gnt_o, 2'b00);

        // Read by requester 1
        sl_mode = 0; sl_lat = 1; sl_rdata = 32'h05060708;
        set_req(1, 1'b0, 10'h010, 32'h0);
        wait_stb("t3");
        chk("t3_s_adr", s_adr_o, 10'h010);
        wait_term(1, "t3");
        chk("t3_rdat", req_dat_o, 32'h05060708);
        chk("t3_ack", req_ack_o, 2'b10);
        clr_req(1);
        repeat (2) @(negedge wb_clk_i);

        // Ack and err together
        sl_mode = 2; sl_lat = 1;
        set_req(0, 1'b1, 10'h020, 32'h11223344);
        wait_stb("t5");
        wait_term(0, "t5");
        chk("t5_err", req_err_o, 2'b01);
        chk("t5_ack", req_ack_o, 2'b00);
        clr_req(0);
        repeat (2) @(negedge wb_clk_i);

        // Silent slave
        sl_mode = 3;
`ifdef ETH_ARB_TIMEOUT_EN
        set_req(0, 1'b1, 10'h030, 32'hcafef00d);
        wait_stb("t4");
        set_req(1, 1'b0, 10'h031, 32'h0);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge wb_clk_i);
            if (req_err_o[0]) begin
                n = i;
                break;
            end
        end
        chk("t4_latency", n, 64);
        chk("t4_timeout_o", timeout_o, 1);
        chk("t4_ack", req_ack_o, 2'b00);
        sl_mode = 0; sl_lat = 1;
        clr_req(0);
        @(negedge wb_clk_i);
        chk("t4_next_gnt", gnt_o, 2'b10);
        wait_term(1, "t4b");
        chk("t4b_ack", req_ack_o, 2'b10);
        chk("t4b_timeout_o", timeout_o, 0);
        clr_req(1);
        repeat (2) @(negedge wb_clk_i);
`else
        set_req(0, 1'b1, 10'h030, 32'hcafef00d);
        wait_stb("t4");
        repeat (80) @(negedge wb_clk_i);
        chk("t4_still_bus", s_cyc_o, 1);
        chk("t4_no_err", req_err_o, 2'b00);
        chk("t4_timeout_o", timeout_o, 0);
        clr_req(0);
        @(negedge wb_clk_i);
        chk("t4_abort_cyc", s_cyc_o, 0);
        chk("t4_abort_ack", req_ack_o, 2'b00);
        chk("t4_abort_err", req_err_o, 2'b00);
        sl_mode = 0;
        repeat (2) @(negedge wb_clk_i);
`endif

        // Reset in the middle of a transfer
        sl_mode = 3;
        set_req(1, 1'b0, 10'h040, 32'h0);
        wait_stb("t6");
        chk("t6_gnt_before", gnt_o, 2'b10);
        set_req(0, 1'b1, 10'h041, 32'h55aa55aa);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        chk("t6_gnt", gnt_o, 0);
        chk("t6_s_cyc", s_cyc_o, 0);
        chk("t6_s_stb", s_stb_o, 0);
        chk("t6_s_adr", s_adr_o, 0);
        chk("t6_s_sel", s_sel_o, 0);
        chk("t6_ack_err", {req_ack_o, req_err_o}, 0);
        chk("t6_rdat", req_dat_o, 0);
        chk("t6_timeout", timeout_o, 0);
        sl_mode = 0; sl_lat = 1;
        @(negedge wb_clk_i);
        chk("t6_first_gnt", gnt_o, 2'b01);
        wait_term(0, "t6a");
        clr_req(0);
        wait_term(1, "t6b");
        chk("t6b_ack", req_ack_o, 2'b10);
        clr_req(1);
        repeat (3) @(negedge wb_clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

endmodule
